// File: rtl/dtw_round_controller.sv
`default_nettype none
// ============================================================================
// Module  : dtw_round_controller
// Purpose : Sequences one scoring round of the dance game. It waits until the
//           camera and reference pose FIFOs both hold a sample, pops one pair
//           into the DTW accelerator, waits the accelerator's fixed latency,
//           then captures and accumulates the per-frame score. The round is
//           bounded by a frame count, protected by a starvation timeout and
//           can be aborted at any time.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           i_start             - one-cycle round request (IDLE only)
//           i_abort             - immediate round end, highest priority
//           i_num_frames[15:0]  - frames in the round, latched on start
//           i_cam_empty         - camera FIFO empty
//           i_ref_empty         - reference FIFO empty
//           o_pop               - read enable to both FIFOs / accel ready
//           i_dtw_score[31:0]   - per-frame accelerator score (unsigned)
//           o_busy              - high in every state except IDLE
//           o_done              - one-cycle pulse on normal/timeout end
//           o_timed_out         - sticky, round ended by starvation
//           o_frame_count[15:0] - frames scored in current/last round
//           o_total_score       - saturating sum of captured scores
//           o_min_score[31:0]   - smallest captured score, all-ones if none
// Revision: 1.0 - initial release
// ============================================================================
module dtw_round_controller #(
  parameter int DTW_LAT = 4,
  parameter int TIMEOUT = 1024,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [15:0]      i_num_frames,
  input  logic             i_cam_empty,
  input  logic             i_ref_empty,
  output logic             o_pop,
  input  logic [31:0]      i_dtw_score,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timed_out,
  output logic [15:0]      o_frame_count,
  output logic [ACC_W-1:0] o_total_score,
  output logic [31:0]      o_min_score
);

  localparam int STARVE_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W    = $clog2(DTW_LAT + 1);

  localparam logic [STARVE_W-1:0] c_TIMEOUT_M1 = STARVE_W'(TIMEOUT - 1);
  localparam logic [LAT_W-1:0]    c_DTW_LAT    = LAT_W'(DTW_LAT);
  localparam logic [LAT_W-1:0]    c_LAT_ONE    = LAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_DATA   = 3'd1,
    S_ISSUE       = 3'd2,
    S_WAIT_RESULT = 3'd3,
    S_DONE        = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_n;
  logic [STARVE_W-1:0]   r_starve;
  logic [LAT_W-1:0]      r_lat;
  logic [15:0]           r_frame_count;
  logic [ACC_W-1:0]      r_total;
  logic [31:0]           r_min;
  logic                  r_timed_out;

  logic                  w_starved;
  logic                  w_start_ok;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_done;
  logic [15:0]           w_frame_inc;
  logic [ACC_W:0]        w_sum;
  logic [ACC_W-1:0]      w_sum_sat;

  assign w_starved   = i_cam_empty | i_ref_empty;
  assign w_frame_inc = r_frame_count + 16'd1;
  // One extra bit catches the carry so the sum can clamp instead of wrapping.
  assign w_sum       = {1'b0, r_total} + (ACC_W + 1)'(i_dtw_score);
  assign w_sum_sat   = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    w_capture  = 1'b0;
    w_start_ok = 1'b0;
    if (i_abort && (r_state != S_IDLE)) begin
      // Abort wins over everything: no pop, no capture, no done pulse.
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            w_start_ok = 1'b1;
            w_next     = (i_num_frames == 16'd0) ? S_DONE : S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (!w_starved) begin
            w_next = S_ISSUE;
          end else if (r_starve == c_TIMEOUT_M1) begin
            w_next = S_DONE;
          end
        end
        S_ISSUE: begin
          w_pop  = 1'b1;
          w_next = S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          if (r_lat == c_LAT_ONE) begin
            w_capture = 1'b1;
            w_next    = (w_frame_inc == r_n) ? S_DONE : S_WAIT_DATA;
          end
        end
        S_DONE: begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n           <= 16'd0;
      r_starve      <= '0;
      r_lat         <= '0;
      r_frame_count <= 16'd0;
      r_total       <= '0;
      r_min         <= '1;
      r_timed_out   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_n           <= i_num_frames;
        r_starve      <= '0;
        r_frame_count <= 16'd0;
        r_total       <= '0;
        r_min         <= '1;
        r_timed_out   <= 1'b0;
      end

      if ((r_state == S_WAIT_DATA) && !i_abort) begin
        if (w_starved) begin
          r_starve <= r_starve + 1'b1;
          if (r_starve == c_TIMEOUT_M1) begin
            r_timed_out <= 1'b1;
          end
        end else begin
          r_starve <= '0;
        end
      end

      // Counter reads DTW_LAT in the first WAIT_RESULT cycle and 1 in the
      // last, so the capture edge sits DTW_LAT+1 edges after the pop edge.
      if (w_pop) begin
        r_lat <= c_DTW_LAT;
      end else if ((r_state == S_WAIT_RESULT) && (r_lat != '0)) begin
        r_lat <= r_lat - 1'b1;
      end

      if (w_capture) begin
        r_frame_count <= w_frame_inc;
        r_total       <= w_sum_sat;
        if (i_dtw_score < r_min) begin
          r_min <= i_dtw_score;
        end
      end
    end
  end

  assign o_pop         = w_pop;
  assign o_done        = w_done;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timed_out   = r_timed_out;
  assign o_frame_count = r_frame_count;
  assign o_total_score = r_total;
  assign o_min_score   = r_min;

endmodule
`default_nettype wire

// File: doc/dtw_round_controller.md
# dtw_round_controller

Sequences one scoring round of the dance game. It waits until the camera-pose and reference-pose FIFOs both hold a sample, then pops one pair into the DTW accelerator. It waits the accelerator's fixed latency, captures the per-frame DTW score and accumulates it. It sits between the two FIFOs and `dtw_accelerator` inside the game loop, and replaces the free-running `ready = !(empty_camera || empty_refer)` pop with a bounded, counted, timeout-protected round.

## Interface
- `DTW_LAT`, 4: cycles from the pop cycle's end to a valid `dtw_score`; must be ≥1.
- `TIMEOUT`, 1024: consecutive starved cycles in WAIT_DATA before the round is ended; must be ≥1.
- `ACC_W`, 40: accumulator width; must be ≥32.
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a round; honoured only in IDLE.
- `abort`  in  1  ends the round immediately; has priority over every other input.
- `num_frames`  in  16  frame pairs in the round; latched when `start` is honoured.
- `cam_empty`  in  1  camera FIFO empty.
- `ref_empty`  in  1  reference FIFO empty.
- `pop`  out  1  read enable driven to both FIFOs and the accelerator `ready`.
- `dtw_score`  in  32  per-frame score from the accelerator, unsigned.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a round ends normally or by timeout.
- `timed_out`  out  1  sticky; set when the round ended by timeout.
- `frame_count`  out  16  frames scored in the current or last round.
- `total_score`  out  ACC_W  saturating sum of captured scores.
- `min_score`  out  32  smallest captured score; all-ones if none.

## Operation
- States: IDLE, WAIT_DATA, ISSUE, WAIT_RESULT, DONE.
- IDLE, with `start`=1 and `abort`=0:
  - latch `num_frames` to `n`;
  - clear `frame_count`, `total_score`, `timed_out` and the starve counter;
  - set `min_score` to all-ones;
  - go to DONE if `n`==0, else to WAIT_DATA.
- WAIT_DATA, both FIFOs non-empty: go to ISSUE and clear the starve counter.
- WAIT_DATA, either FIFO empty:
  - increment the starve counter;
  - when it reaches `TIMEOUT`, set `timed_out` and go to DONE.
- ISSUE: lasts exactly one cycle with `pop`=1; load the latency counter with `DTW_LAT`; go to WAIT_RESULT.
- WAIT_RESULT: decrement the latency counter each cycle. On the cycle it reads 1:
  - capture `dtw_score`;
  - `total_score` += score, saturating at 2^ACC_W−1;
  - `min_score` = min(`min_score`, score);
  - `frame_count` += 1;
  - if the new `frame_count` == `n`, go to DONE, else go to WAIT_DATA.
- DONE: `done`=1 for this one cycle; the next state is IDLE.
- `abort`=1 in any non-IDLE state: next state is IDLE.
  - No `done` pulse and no capture that cycle.
  - Result registers hold their partial values.
  - `pop` is 0 in the abort cycle, even in ISSUE.
- `start` is ignored while `busy`=1.
- `pop` is asserted only in ISSUE, so the FIFOs are never popped while empty.

## Timing
- Reset: state IDLE; `pop`, `busy`, `done` and `timed_out` are 0; `frame_count` and `total_score` are 0; `min_score` is all-ones.
- `start` sampled at edge e: `busy`=1 from e+1; state is WAIT_DATA at e+1.
- FIFOs non-empty at edge e while in WAIT_DATA: `pop` is high for the cycle between e+1 and e+2.
- If `pop` is high in cycle k, `dtw_score` is captured at edge k+1+`DTW_LAT`. Results update on that edge.
- Minimum per-frame period is `DTW_LAT`+2 cycles: WAIT_DATA 1, ISSUE 1, WAIT_RESULT `DTW_LAT`.
- Capture of the last frame at edge e gives `done`=1 in the cycle after e. `busy` falls one cycle later.
- Timeout: `done` is asserted in the cycle after the `TIMEOUT`-th consecutive starved cycle.
- Outputs are registered except `pop` and `done`, which are decoded from state.

## Test plan
- Reset, then `num_frames`=3, FIFOs always non-empty, scores 10/7/20 → exactly 3 `pop` pulses spaced 6 cycles apart (`DTW_LAT`=4). `total_score`=37, `min_score`=7, `frame_count`=3, one `done` pulse, `timed_out`=0.
- `num_frames`=0 → `done` pulses 2 cycles after `start`, `pop` never asserted, `total_score`=0, `min_score`=0xFFFFFFFF.
- `cam_empty` held high for 5 cycles mid-round, `TIMEOUT`=8 → `pop` deferred until data is present, round completes normally. Holding `cam_empty` for 8 cycles instead → `timed_out`=1, `done` pulses, `frame_count` shows the frames completed so far.
- Four scores of 0xFFFFFFFF with `ACC_W`=33 → `total_score` saturates at 0x1_FFFFFFFF.
- `abort` asserted in ISSUE during frame 2 → `pop` is 0 that cycle, state returns to IDLE with no `done`, `frame_count`=1. A following `start` runs a clean round.
- `start` pulsed again while `busy` → ignored; `n` and the counters are unaffected.
- `rst` asserted mid-WAIT_RESULT with no clock running → all outputs reach their reset values immediately.
